// File: rtl/biriscv_redirect_ctrl.sv
// Fetch redirect controller: prioritises exception/branch redirects, tracks fetch privilege
// and sequences FENCE.I (invalidate, wait for flush, redirect). Every output is a flop.
module biriscv_redirect_ctrl #(
  parameter int unsigned FLUSH_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_request_i,
  input  logic [31:0] exc_pc_i,
  input  logic [1:0]  exc_priv_i,
  input  logic        br_request_i,
  input  logic [31:0] br_pc_i,
  input  logic        fence_request_i,
  input  logic [31:0] fence_pc_i,
  input  logic        flush_done_i,
  output logic        branch_request_o,
  output logic [31:0] branch_pc_o,
  output logic [1:0]  branch_priv_o,
  output logic        fetch_invalidate_o,
  output logic        squash_o,
  output logic        busy_o,
  output logic        fence_done_o,
  output logic        flush_timeout_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_WAIT, ST_REDIRECT} state_t;

  // A zero timeout means wait forever; TMO_LAST is then never consulted.
  localparam bit          TMO_EN   = (FLUSH_TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = 16'(FLUSH_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  priv_q, priv_d;
  logic [31:0] fence_pc_q, fence_pc_d;
  logic        cancel_q, cancel_d;
  logic [15:0] cnt_q, cnt_d;

  logic        br_req_q, br_req_d;
  logic [31:0] br_pc_q, br_pc_d;
  logic [1:0]  br_priv_q, br_priv_d;
  logic        inv_q, inv_d;
  logic        squash_q, squash_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;

  always_comb begin
    state_d    = state_q;
    priv_d     = priv_q;
    fence_pc_d = fence_pc_q;
    cancel_d   = cancel_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    br_req_d   = 1'b0;
    br_pc_d    = br_pc_q;
    br_priv_d  = br_priv_q;
    inv_d      = 1'b0;
    done_d     = 1'b0;

    if (exc_request_i) begin
      br_req_d  = 1'b1;
      br_pc_d   = exc_pc_i;
      br_priv_d = exc_priv_i;
      priv_d    = exc_priv_i;
      if (state_q == ST_FLUSH || state_q == ST_WAIT) cancel_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!exc_request_i) begin
          if (br_request_i) begin
            br_req_d  = 1'b1;
            br_pc_d   = br_pc_i;
            br_priv_d = priv_q;
          end else if (fence_request_i) begin
            fence_pc_d = fence_pc_i;
            inv_d      = 1'b1;
            state_d    = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (flush_done_i) begin
          state_d = ST_REDIRECT;
        end else if (TMO_EN && cnt_q == TMO_LAST) begin
          state_d = ST_REDIRECT;
          tmo_d   = 1'b1;
        end
      end
      ST_REDIRECT: begin
        state_d  = ST_IDLE;
        cancel_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // A cancelled fence still reports completion but must not redirect over the exception.
    if (state_q == ST_WAIT && state_d == ST_REDIRECT) begin
      done_d = 1'b1;
      if (!cancel_d) begin
        br_req_d  = 1'b1;
        br_pc_d   = fence_pc_q;
        br_priv_d = priv_q;
      end
    end

    squash_d = br_req_d | inv_d;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      priv_q     <= 2'b11;
      fence_pc_q <= '0;
      cancel_q   <= 1'b0;
      cnt_q      <= '0;
      br_req_q   <= 1'b0;
      br_pc_q    <= '0;
      br_priv_q  <= 2'b11;
      inv_q      <= 1'b0;
      squash_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      priv_q     <= priv_d;
      fence_pc_q <= fence_pc_d;
      cancel_q   <= cancel_d;
      cnt_q      <= cnt_d;
      br_req_q   <= br_req_d;
      br_pc_q    <= br_pc_d;
      br_priv_q  <= br_priv_d;
      inv_q      <= inv_d;
      squash_q   <= squash_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  assign branch_request_o   = br_req_q;
  assign branch_pc_o        = br_pc_q;
  assign branch_priv_o      = br_priv_q;
  assign fetch_invalidate_o = inv_q;
  assign squash_o           = squash_q;
  assign busy_o             = busy_q;
  assign fence_done_o       = done_q;
  assign flush_timeout_o    = tmo_q;

endmodule
